// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard frame receiver that folds E0/F0 prefixes into flags
// on a single held scan code, with parity, stop-bit and timeout error pulses.
module ps2_scancode_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic [3:0] code_hi,
    output logic [3:0] code_lo,
    output logic       code_ext,
    output logic       code_break,
    output logic       code_valid,
    output logic       frame_err
);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic clk_m, clk_s, clk_d, dat_m, dat_s, fe, timeout;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic acc, par_ok, ext_pend, brk_pend;
    logic [WW-1:0] wdog;
    assign fe = clk_d & ~clk_s;
    assign timeout = (state != IDLE) && (wdog == WW'(TIMEOUT_CYCLES - 1));
    assign code_hi = code[7:4];
    assign code_lo = code[3:0];
    always_comb begin
        state_n = state;
        if (timeout)
            state_n = IDLE;
        else if (fe)
            case (state)
                IDLE:    state_n = dat_s ? IDLE : DATA;
                DATA:    state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY:  state_n = STOP;
                default: state_n = IDLE;
            endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            // Idle bus level, so leaving reset never fakes a falling edge
            {clk_m, clk_s, clk_d, dat_m, dat_s} <= '1;
            state <= IDLE;
            bit_cnt <= '0;
            shreg <= '0;
            acc <= 1'b0;
            par_ok <= 1'b0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            wdog <= '0;
            code <= '0;
            code_ext <= 1'b0;
            code_break <= 1'b0;
            code_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            {clk_m, clk_s, clk_d} <= {ps2_clk, clk_m, clk_s};
            {dat_m, dat_s} <= {ps2_dat, dat_m};
            state <= state_n;
            wdog <= (fe || state_n == IDLE) ? '0 : wdog + 1'b1;
            code_valid <= 1'b0;
            frame_err <= 1'b0;
            if (timeout) begin
                frame_err <= 1'b1;
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (fe) begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        acc <= 1'b0;
                    end
                    DATA: begin
                        shreg <= {dat_s, shreg[7:1]};
                        acc <= acc ^ dat_s;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: par_ok <= acc ^ dat_s;
                    default: begin
                        if (dat_s && par_ok) begin
                            if (shreg == 8'hE0)
                                ext_pend <= 1'b1;
                            else if (shreg == 8'hF0)
                                brk_pend <= 1'b1;
                            else begin
                                code <= shreg;
                                code_ext <= ext_pend;
                                code_break <= brk_pend;
                                code_valid <= 1'b1;
                                ext_pend <= 1'b0;
                                brk_pend <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            ext_pend <= 1'b0;
                            brk_pend <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: directed PS/2 frames with hand-computed expected codes and flags.
module tb_ps2_scancode_rx;
    logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
    logic [7:0] code;
    logic [3:0] code_hi, code_lo;
    logic code_ext, code_break, code_valid, frame_err;
    int checks = 0, failures = 0, nvalid = 0, nerr = 0;

    ps2_scancode_rx #(.TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .code(code), .code_hi(code_hi), .code_lo(code_lo), .code_ext(code_ext),
        .code_break(code_break), .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Counts high cycles, so a one-frame pulse must show up as exactly 1
    always @(negedge clk) begin
        if (code_valid) nvalid++;
        if (frame_err) nerr++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic v);
        ps2_dat = v;
        tick(10);
        ps2_clk = 1'b0;
        tick(10);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_dat = 1'b1;
        tick(20);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(10);
        checks++; if (code !== 8'h00) begin failures++; $display("FAIL reset_code got=%h exp=00", code); end
        checks++; if ({code_ext, code_break, code_valid, frame_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {code_ext, code_break, code_valid, frame_err}); end
        checks++; if (nvalid + nerr !== 0) begin failures++; $display("FAIL reset_pulses got=%0d exp=0", nvalid + nerr); end
    endtask

    task automatic test_make;
        int v0 = nvalid, e0 = nerr;
        send_frame(8'h1C, 1'b0, 1'b0);
        checks++; if (nvalid - v0 !== 1) begin failures++; $display("FAIL make_valid got=%0d exp=1", nvalid - v0); end
        checks++; if (nerr - e0 !== 0) begin failures++; $display("FAIL make_err got=%0d exp=0", nerr - e0); end
        checks++; if (code !== 8'h1C) begin failures++; $display("FAIL make_code got=%h exp=1c", code); end
        checks++; if ({code_hi, code_lo} !== 8'h1C) begin failures++; $display("FAIL make_nibbles got=%h/%h exp=1/c", code_hi, code_lo); end
        checks++; if ({code_ext, code_break} !== 2'b00) begin failures++; $display("FAIL make_flags got=%b exp=00", {code_ext, code_break}); end
    endtask

    task automatic test_break;
        int v0 = nvalid;
        send_frame(8'hF0, 1'b0, 1'b0);
        checks++; if (nvalid - v0 !== 0) begin failures++; $display("FAIL prefix_valid got=%0d exp=0", nvalid - v0); end
        send_frame(8'h1C, 1'b0, 1'b0);
        checks++; if (nvalid - v0 !== 1) begin failures++; $display("FAIL break_valid got=%0d exp=1", nvalid - v0); end
        checks++; if ({code, code_ext, code_break} !== {8'h1C, 2'b01}) begin failures++; $display("FAIL break_code got=%h/%b%b exp=1c/01", code, code_ext, code_break); end
    endtask

    task automatic test_ext_break;
        int v0 = nvalid;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        checks++; if (code !== 8'h1C) begin failures++; $display("FAIL prefix_code got=%h exp=1c", code); end
        send_frame(8'h75, 1'b0, 1'b0);
        checks++; if (nvalid - v0 !== 1) begin failures++; $display("FAIL extbrk_valid got=%0d exp=1", nvalid - v0); end
        checks++; if ({code, code_ext, code_break} !== {8'h75, 2'b11}) begin failures++; $display("FAIL extbrk_code got=%h/%b%b exp=75/11", code, code_ext, code_break); end
        send_frame(8'h75, 1'b0, 1'b0);
        checks++; if ({code, code_ext, code_break} !== {8'h75, 2'b00}) begin failures++; $display("FAIL plain75_code got=%h/%b%b exp=75/00", code, code_ext, code_break); end
    endtask

    task automatic test_parity;
        int v0, e0;
        send_frame(8'h1C, 1'b0, 1'b0);
        v0 = nvalid; e0 = nerr;
        send_frame(8'h29, 1'b1, 1'b0);
        checks++; if (nerr - e0 !== 1) begin failures++; $display("FAIL parity_err got=%0d exp=1", nerr - e0); end
        checks++; if (nvalid - v0 !== 0) begin failures++; $display("FAIL parity_valid got=%0d exp=0", nvalid - v0); end
        checks++; if (code !== 8'h1C) begin failures++; $display("FAIL parity_code got=%h exp=1c", code); end
        e0 = nerr;
        send_frame(8'hF0, 1'b0, 1'b1);
        checks++; if (nerr - e0 !== 1) begin failures++; $display("FAIL stop_err got=%0d exp=1", nerr - e0); end
        send_frame(8'h1C, 1'b0, 1'b0);
        checks++; if ({code, code_break} !== {8'h1C, 1'b0}) begin failures++; $display("FAIL stop_clears_brk got=%h/%b exp=1c/0", code, code_break); end
    endtask

    task automatic test_timeout;
        int v0 = nvalid, e0 = nerr, n = 0;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        ps2_dat = 1'b0;
        tick(10);
        ps2_clk = 1'b0;
        while (!frame_err && n < 400) begin
            tick(1);
            n++;
            if (n == 10) ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        // pin fall -> fe 2-3 cycles, 200 quiet cycles to terminal count, +1 registered pulse
        checks++; if (n < 201 || n > 205) begin failures++; $display("FAIL timeout_latency got=%0d exp=201..205", n); end
        tick(20);
        checks++; if (nerr - e0 !== 1 || nvalid - v0 !== 0) begin failures++; $display("FAIL timeout_pulses got=%0d/%0d exp=1/0", nerr - e0, nvalid - v0); end
        send_frame(8'h29, 1'b0, 1'b0);
        checks++; if (nvalid - v0 !== 1 || code !== 8'h29) begin failures++; $display("FAIL after_timeout got=%0d/%h exp=1/29", nvalid - v0, code); end
    endtask

    task automatic test_reset_mid;
        int v0, e0;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        ps2_dat = 1'b0;
        tick(3);
        v0 = nvalid; e0 = nerr;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        ps2_dat = 1'b1;
        tick(300);
        checks++; if ({code, code_ext, code_break} !== 10'b0) begin failures++; $display("FAIL midreset_outputs got=%h/%b%b exp=00/00", code, code_ext, code_break); end
        checks++; if (nvalid - v0 !== 0 || nerr - e0 !== 0) begin failures++; $display("FAIL midreset_pulses got=%0d/%0d exp=0/0", nvalid - v0, nerr - e0); end
        send_frame(8'h1C, 1'b0, 1'b0);
        checks++; if (nvalid - v0 !== 1 || code !== 8'h1C || {code_ext, code_break} !== 2'b00) begin failures++; $display("FAIL midreset_next got=%0d/%h/%b%b exp=1/1c/00", nvalid - v0, code, code_ext, code_break); end
    endtask

    initial begin
        test_reset;
        test_make;
        test_break;
        test_ext_break;
        test_parity;
        test_timeout;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

- Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity, stop) and resolves E0 (extended) and F0 (break) prefixes into flags on a single decoded scan code.
- Sits directly upstream of the seven-segment decoders: its `code_hi` / `code_lo` nibbles drive two `hex_display` instances.
- Exposes a one-cycle valid pulse for game logic.
- Oversamples the keyboard clock with the system clock; has no clock-domain crossing beyond its input synchronizers.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50000: system-clock cycles without a PS/2 clock falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock. One clock domain for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_dat`  in  1  raw PS/2 data pin, asynchronous.
- `code`  out  8  last accepted non-prefix scan code, held.
- `code_hi`  out  4  `code[7:4]`, for the left hex digit.
- `code_lo`  out  4  `code[3:0]`, for the right hex digit.
- `code_ext`  out  1  `code` was preceded by E0.
- `code_break`  out  1  `code` was preceded by F0 (key release).
- `code_valid`  out  1  one-cycle pulse when `code` / flags update.
- `frame_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
**Synchronizers**
- Two-flop synchronizer on each pin, giving `clk_s` and `dat_s`.
- A third flop holds `clk_s` as `clk_d`.
- Falling edge is `fe = clk_d & ~clk_s`.
- Every bit sample uses `dat_s` in the `fe` cycle.

**FSM states: IDLE, DATA, PARITY, STOP**
- IDLE:
  - `fe` with `dat_s`=0 → DATA, bit counter = 0, parity accumulator = 0.
  - `fe` with `dat_s`=1 is ignored; stay in IDLE.
- DATA:
  - On each `fe`, shift `dat_s` in at bit 7 (right shift, LSB first) and XOR it into the accumulator.
  - After the 8th bit → PARITY.
- PARITY:
  - On `fe`, the frame's parity is good when `accumulator ^ dat_s` = 1 (odd).
  - Record the result → STOP.
- STOP:
  - On `fe`, the frame is good when `dat_s`=1 and parity is good.
  - Always → IDLE.

**Good frame**
- Byte E0: set `ext_pend`.
- Byte F0: set `brk_pend`.
- Any other byte:
  - `code` ← byte, `code_ext` ← `ext_pend`, `code_break` ← `brk_pend`.
  - Pulse `code_valid`.
  - Clear both pend bits.
- Prefix bytes never pulse `code_valid` and never change `code`.

**Bad frame** (parity or stop error)
- Pulse `frame_err` and clear both pend bits.
- `code`, `code_ext` and `code_break` are unchanged.

**Timeout**
- The watchdog counter runs only outside IDLE and clears on every `fe` and on entry to IDLE.
- When it reaches `TIMEOUT_CYCLES-1`: go to IDLE, pulse `frame_err`, clear the pend bits, discard partial data.
- An `fe` in the same cycle as the terminal count is not processed as a bit; timeout wins.
- The counter is sized by `$clog2(TIMEOUT_CYCLES)`.

## Timing
**Reset**
- All outputs are 0; FSM in IDLE; pend bits and counters 0.
- Synchronizer and `clk_d` flops reset to 1 (idle bus), so no spurious `fe` occurs after reset.
- Reset mid-frame discards the frame. No `frame_err` is issued for it.

**Latency**
- A pin falling edge becomes `fe` 2–3 `clk` cycles later.
- `code_valid` / `frame_err` assert in the cycle after the stop-bit `fe`, for exactly 1 cycle.
- `code`, `code_hi`, `code_lo`, `code_ext` and `code_break` change in that same cycle and hold until the next valid code.

**Other rules**
- `code_hi` / `code_lo` are pure wiring of the registered `code`.
- No handshake; consumers must sample on `code_valid`.
- Maximum rate is one code per frame (about 11 PS/2 clocks).
- Pins are assumed to change no faster than 1/4 of `clk`; 10–16.7 kHz PS/2 clock against `clk` ≥ 1 MHz meets this.

## Test plan
1. **Plain make code.** Reset, then send frame 0x1C (data 0,0,1,1,1,0,0,0; parity 0; stop 1) → single `code_valid`, `code`=0x1C, `code_hi`=1, `code_lo`=C, `code_ext`=0, `code_break`=0, no `frame_err`.
2. **Break code.** Send F0 then 1C → exactly one `code_valid` (after 1C), `code`=0x1C, `code_break`=1, `code_ext`=0.
3. **Extended break.** Send E0, F0, 75 → one `code_valid`, `code`=0x75, `code_ext`=1, `code_break`=1. Then send 75 → `code_ext`=0, `code_break`=0.
4. **Parity error.** Send 0x29 with parity bit 1 (should be 0) after a prior valid 0x1C → `frame_err` pulse, no `code_valid`, `code` stays 0x1C. Send F0 (bad stop) then 1C → `code_break`=0.
5. **Timeout.** Send start plus 4 data bits, then hold `ps2_clk` high for `TIMEOUT_CYCLES` (set to 200 for sim) → `frame_err` at cycle 199 after the last `fe`, FSM in IDLE. Next frame 0x29 → `code`=0x29, valid.
6. **Reset mid-frame.** Assert `reset` for 1 cycle during bit 5 of a frame → all outputs 0, no pulses. Following frame 0x1C → decoded correctly.
